pb_debounce: RTL

Push-button conditioning stage that sits directly upstream of the lab's flip-flop and sequential-logic stages. It takes a raw, asynchronous, bouncing button input and synchronizes it to `clk`. It then samples the button on a slow periodic tick and qualifies each level change over several consecutive identical samples. It delivers a clean debounced level plus single-cycle press and release pulses that downstream D inputs and enables can consume directly.

---
 rtl/pb_debounce_if.sv | 22 ++
 rtl/pb_debounce.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pb_debounce_if.sv
// Push-button debounce bundle: raw button in, clean level and pulses out.
// master drives pb_in; slave (the debouncer) drives db_level/db_press/db_release.
interface pb_debounce_if;
   logic pb_in;
   logic db_level;
   logic db_press;
   logic db_release;

   modport master (
      output pb_in,
      input  db_level,
      input  db_press,
      input  db_release
   );

   modport slave (
      input  pb_in,
      output db_level,
      output db_press,
      output db_release
   );
endinterface

// File: rtl/pb_debounce.sv
// Push-button debouncer: 2-flop sync, periodic sample tick, N-sample qualify.
// Ports: clk, reset (async, active-high), bus (slave: pb_in -> db_level/press/release).
module pb_debounce #(
   parameter int TICK_COUNT = 250000,
   parameter int SAMPLES    = 4
) (
   input  logic         clk,
   input  logic         reset,
   pb_debounce_if.slave bus
);

   localparam int CW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_COUNT - 1);
   localparam logic [3:0]    SAMP      = 4'(SAMPLES);

   typedef enum logic [1:0] {
      ST_LOW,
      ST_CHK_HIGH,
      ST_HIGH,
      ST_CHK_LOW
   } state_t;

   logic          s1_q;
   logic          s2_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          tick;
   state_t        state_q;
   state_t        state_d;
   logic [3:0]    match_q;
   logic [3:0]    match_d;
   logic [3:0]    match_inc;
   logic          level_q;
   logic          level_d;
   logic          press_q;
   logic          press_d;
   logic          release_q;
   logic          release_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= bus.pb_in;
         s2_q <= s1_q;
      end
   end

   assign tick  = (cnt_q == TICK_LAST);
   assign cnt_d = tick ? '0 : cnt_q + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_LOW;
         match_q   <= 4'd0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         match_q   <= match_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      match_d   = match_q;
      match_inc = match_q + 4'd1;
      if (tick) begin
         unique case (state_q)
            ST_LOW: begin
               if (s2_q) begin
                  state_d = ST_CHK_HIGH;
                  match_d = 4'd1;
               end
            end
            ST_CHK_HIGH: begin
               if (!s2_q) begin
                  state_d = ST_LOW;
                  match_d = 4'd0;
               end else if (match_inc == SAMP) begin
                  state_d = ST_HIGH;
                  match_d = 4'd0;
               end else begin
                  match_d = match_inc;
               end
            end
            ST_HIGH: begin
               if (!s2_q) begin
                  state_d = ST_CHK_LOW;
                  match_d = 4'd1;
               end
            end
            ST_CHK_LOW: begin
               if (s2_q) begin
                  state_d = ST_HIGH;
                  match_d = 4'd0;
               end else if (match_inc == SAMP) begin
                  state_d = ST_LOW;
                  match_d = 4'd0;
               end else begin
                  match_d = match_inc;
               end
            end
            default: begin
               state_d = ST_LOW;
               match_d = 4'd0;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so the level and its
   // edge pulse appear together in the first cycle of the new state.
   always_comb begin
      level_d   = (state_d == ST_HIGH) || (state_d == ST_CHK_LOW);
      press_d   = (state_q == ST_CHK_HIGH) && (state_d == ST_HIGH);
      release_d = (state_q == ST_CHK_LOW) && (state_d == ST_LOW);
   end

   assign bus.db_level   = level_q;
   assign bus.db_press   = press_q;
   assign bus.db_release = release_q;

endmodule
